// File: rtl/fht_stage_sequencer.sv
// Stage/address sequencer for the 4-bank radix-2 FHT core.
// Define FHT_CTRL_HALF_RATE_EN for two-cycle ticks (WE on the second cycle).
module fht_stage_sequencer #(
  parameter int A_BIT    = 9,
  parameter int PIPE_LAT = 3,
  parameter int ST_BIT   = 5
) (
  input  logic              iCLK,
  input  logic              iRESET,
  input  logic              iSTART,
  input  logic [3:0]        iLOG_LEN,
  input  logic              iCE,
  input  logic              iHOLD,
  output logic              oRDY,
  output logic              oDONE,
  output logic [ST_BIT-1:0] oSTAGE,
  output logic              oST_ZERO,
  output logic              oST_LAST,
  output logic [A_BIT-1:0]  oSECTOR,
  output logic              o2ND_HALF,
  output logic              oRD_VALID,
  output logic [A_BIT-1:0]  oADDR_RD_EVEN,
  output logic [A_BIT-1:0]  oADDR_RD_ODD,
  output logic [A_BIT-1:0]  oADDR_WR_EVEN,
  output logic [A_BIT-1:0]  oADDR_WR_ODD,
  output logic [A_BIT-1:0]  oADDR_COEF,
  output logic              oWE_A,
  output logic              oWE_B,
  output logic              oSOURCE
);

  localparam int TW = A_BIT + 5;
  localparam logic [3:0] LMAX = 4'(A_BIT);
  localparam logic [A_BIT:0] ONE = {{A_BIT{1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            r_st;
  logic [3:0]        r_len;
  logic [ST_BIT-1:0] r_s;
  logic [TW-1:0]     r_t;
  logic              r_src;

  logic              w_qual;
  logic              w_tick;
  logic              w_load;
  logic [3:0]        w_len_in;
  logic [TW-1:0]     w_bl;
  logic              w_t_last;
  logic              w_s_last;
  logic              w_s0;
  logic [ST_BIT-1:0] w_ld;
  logic [A_BIT:0]    w_mask;
  logic              w_rd_ok;
  logic              w_wr_ok;
  logic [A_BIT-1:0]  w_rrow;
  logic [A_BIT-1:0]  w_wrow;
  logic [A_BIT:0]    w_roff;
  logic [A_BIT:0]    w_woff;
  logic              w_bypass;
  logic [A_BIT-1:0]  w_coef;
  logic [A_BIT-1:0]  w_sec;
  logic              w_half;

  // Mirror the offset inside its sector: k*D + ((D-o) mod D)
  function automatic logic [A_BIT-1:0] f_odd(
    input logic [A_BIT-1:0] row,
    input logic [A_BIT:0]   mask,
    input logic             bypass
  );
    logic [A_BIT:0] o;
    logic [A_BIT:0] m;
    o = {1'b0, row} & mask;
    m = ({1'b0, row} & ~mask) | ((mask + ONE - o) & mask);
    return bypass ? row : m[A_BIT-1:0];
  endfunction

`ifdef FHT_CTRL_HALF_RATE_EN
  logic r_ph;
  assign w_qual = (r_st == S_RUN) & iCE & ~iHOLD;
  assign w_load = w_qual & ~r_ph;
  assign w_tick = w_qual & r_ph;
`else
  assign w_qual = (r_st == S_RUN) & iCE & ~iHOLD;
  assign w_load = w_qual;
  assign w_tick = w_qual;
`endif

  assign w_len_in = (iLOG_LEN < 4'd2) ? 4'd2 :
                    (iLOG_LEN > LMAX) ? LMAX : iLOG_LEN;
  assign w_bl     = TW'(1) << r_len;
  assign w_t_last = (r_t == w_bl + TW'(PIPE_LAT) - TW'(1));
  assign w_s_last = (r_s == ST_BIT'(r_len) + ST_BIT'(1));
  assign w_s0     = (r_s == '0);
  assign w_ld     = w_s0 ? ST_BIT'(r_len)
                         : ST_BIT'(r_len) - r_s + ST_BIT'(1);
  assign w_mask   = (ONE << w_ld) - ONE;
  assign w_rd_ok  = (r_t < w_bl);
  assign w_wr_ok  = (r_t >= TW'(PIPE_LAT));
  assign w_rrow   = A_BIT'(r_t);
  assign w_wrow   = A_BIT'(r_t - TW'(PIPE_LAT));
  assign w_roff   = {1'b0, w_rrow} & w_mask;
  assign w_woff   = {1'b0, w_wrow} & w_mask;
  assign w_bypass = w_s0 | w_s_last;
  assign w_coef   = w_s0 ? '0
                         : A_BIT'(w_roff << (r_s - ST_BIT'(1)));
  assign w_sec    = A_BIT'({1'b0, w_rrow} >> w_ld);
  assign w_half   = ~w_s0 & (w_mask != '0) &
                    (w_woff >= ((w_mask + ONE) >> 1));

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      r_st          <= S_IDLE;
      r_len         <= 4'd2;
      r_s           <= '0;
      r_t           <= '0;
      r_src         <= 1'b0;
`ifdef FHT_CTRL_HALF_RATE_EN
      r_ph          <= 1'b0;
`endif
      oRDY          <= 1'b1;
      oDONE         <= 1'b0;
      oSTAGE        <= '0;
      oST_ZERO      <= 1'b0;
      oST_LAST      <= 1'b0;
      oSECTOR       <= '0;
      o2ND_HALF     <= 1'b0;
      oRD_VALID     <= 1'b0;
      oADDR_RD_EVEN <= '0;
      oADDR_RD_ODD  <= '0;
      oADDR_WR_EVEN <= '0;
      oADDR_WR_ODD  <= '0;
      oADDR_COEF    <= '0;
      oWE_A         <= 1'b0;
      oWE_B         <= 1'b0;
      oSOURCE       <= 1'b0;
    end else begin
      oDONE     <= 1'b0;
      oRD_VALID <= 1'b0;
      oWE_A     <= 1'b0;
      oWE_B     <= 1'b0;
      unique case (r_st)
        S_IDLE: begin
          if (iSTART) begin
            r_st  <= S_RUN;
            oRDY  <= 1'b0;
            r_len <= w_len_in;
            r_s   <= '0;
            r_t   <= '0;
            r_src <= 1'b0;
`ifdef FHT_CTRL_HALF_RATE_EN
            r_ph  <= 1'b0;
`endif
          end
        end
        S_RUN: begin
`ifdef FHT_CTRL_HALF_RATE_EN
          if (w_qual) r_ph <= ~r_ph;
`endif
          if (w_load) begin
            oSTAGE    <= r_s;
            oST_ZERO  <= w_s0;
            oST_LAST  <= w_s_last;
            oSOURCE   <= r_src;
            oRD_VALID <= w_rd_ok;
            if (w_rd_ok) begin
              oADDR_RD_EVEN <= w_rrow;
              oADDR_RD_ODD  <= f_odd(w_rrow, w_mask, w_bypass);
              oSECTOR       <= w_sec;
              oADDR_COEF    <= w_coef;
            end
            if (w_wr_ok) begin
              oADDR_WR_EVEN <= w_wrow;
              oADDR_WR_ODD  <= f_odd(w_wrow, w_mask, w_bypass);
              o2ND_HALF     <= w_half;
            end
          end
          if (w_tick) begin
            oWE_A <= w_wr_ok & r_s[0];
            oWE_B <= w_wr_ok & ~r_s[0];
            if (w_t_last) begin
              r_t <= '0;
              if (w_s_last) begin
                r_st  <= S_DONE;
                oDONE <= 1'b1;
              end else begin
                r_s   <= r_s + ST_BIT'(1);
                r_src <= ~r_src;
              end
            end else begin
              r_t <= r_t + TW'(1);
            end
          end
        end
        S_DONE: begin
          r_st          <= S_IDLE;
          oRDY          <= 1'b1;
          r_s           <= '0;
          oSTAGE        <= '0;
          oST_ZERO      <= 1'b0;
          oST_LAST      <= 1'b0;
          oSECTOR       <= '0;
          o2ND_HALF     <= 1'b0;
          oADDR_RD_EVEN <= '0;
          oADDR_RD_ODD  <= '0;
          oADDR_WR_EVEN <= '0;
          oADDR_WR_ODD  <= '0;
          oADDR_COEF    <= '0;
          oSOURCE       <= 1'b0;
        end
        default: r_st <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/fht_stage_sequencer.md
Name: fht_stage_sequencer

Overview:
Runtime-configurable stage/address sequencer for the 4-bank radix-2 FHT core: the next generation of the fixed-size FHT controller. Transform length is selectable per run and the butterfly pipeline latency is a parameter. Adds a stall input, clock-enable pacing and a done pulse. It drives read/write addresses, coefficient address, write enables and ping-pong select for the bank mixers and butterfly datapath.

Parameters:
A_BIT, 9, max bank address width; max bank depth 2^A_BIT, max transform size 4*2^A_BIT.
PIPE_LAT, 3, ticks from read address issue to write address of the same row (1..15).
ST_BIT, 5, width of stage index output.

Ports:
iCLK  in  1  clock.
iRESET  in  1  synchronous reset, active-high.
iSTART  in  1  start request; accepted only when oRDY=1.
iLOG_LEN  in  4  log2(bank depth) L for this run; sampled at accepted iSTART.
iCE  in  1  tick enable; counters advance only on iCE=1 cycles.
iHOLD  in  1  stall; freezes all state, forces write enables low.
oRDY  out  1  idle, ready for iSTART.
oDONE  out  1  one-cycle pulse at end of run.
oSTAGE  out  ST_BIT  current stage s.
oST_ZERO  out  1  s==0 and running.
oST_LAST  out  1  s==L+1.
oSECTOR  out  A_BIT  sector index k of current read row.
o2ND_HALF  out  1  write-side row offset >= D/2 (0 when D==1 or s==0).
oRD_VALID  out  1  read address valid this tick.
oADDR_RD_EVEN  out  A_BIT  read address for banks 0,2.
oADDR_RD_ODD  out  A_BIT  read address for banks 1,3.
oADDR_WR_EVEN  out  A_BIT  write address for banks 0,2.
oADDR_WR_ODD  out  A_BIT  write address for banks 1,3.
oADDR_COEF  out  A_BIT  twiddle ROM address.
oWE_A  out  1  write enable, set A (odd stages).
oWE_B  out  1  write enable, set B (even stages).
oSOURCE  out  1  read-set select; 0 = set B... toggles each stage, 0 in stage 0.

Behaviour:
- All outputs registered. Reset: oRDY=1, every other output 0. Reset mid-run aborts immediately to IDLE without oDONE.
- L = iLOG_LEN clamped to [2, A_BIT]; latched at start. BANK_LEN = 2^L. Stage count = L+2 (s = 0..L+1).
- Sector size D: s=0 -> BANK_LEN; s>=1 -> BANK_LEN >> (s-1) (s=L+1 gives D=1).
- FSM: IDLE --iSTART--> RUN (s=0, t=0) ; RUN --last tick of s=L+1--> DONE ; DONE -> IDLE (oDONE=1 for this single cycle, oRDY returns next cycle). iSTART while not IDLE ignored.
- Tick = cycle with iCE=1 and iHOLD=0. Stage tick counter t = 0..BANK_LEN+PIPE_LAT-1, then s increments, t=0.
- Read: t < BANK_LEN -> oRD_VALID=1, row r=t, k=r>>log2(D), o=r&(D-1). EVEN addr = r. ODD addr = r if s==0 or s==L+1, else k*D + ((D-o) mod D).
- Coefficient: oADDR_COEF = 0 for s==0, else o << (s-1), truncated to A_BIT.
- Write: row w = r delayed PIPE_LAT ticks; valid for PIPE_LAT <= t < BANK_LEN+PIPE_LAT. EVEN addr = w; ODD addr uses the read mapping applied to w with same D.
- oWE_A on valid write ticks of odd s, oWE_B on even s; both low on non-tick cycles and while iHOLD=1.
- oSOURCE toggles at every stage boundary; 0 in stage 0.
- iHOLD/iCE low: addresses hold last value, no counter moves; simultaneous iHOLD and stage boundary: boundary deferred.
- Address arithmetic modulo 2^A_BIT; unused upper bits zero when L<A_BIT.

Optional Feature:
FHT_CTRL_HALF_RATE_EN: defined -> internal toggle divides ticks by 2 (tick only on every second qualifying cycle, counted from RUN entry); write enables asserted only on the second cycle of each tick pair, matching a two-cycle RAM mixer. Undefined -> one tick per qualifying cycle, write enable lasts the tick cycle.

Test Plan:
A_BIT=4, PIPE_LAT=2, iLOG_LEN=3, iCE=1, start at cycle 0 -> 5 stages x 10 ticks; oDONE exactly one pulse at cycle 51, oRDY=1 at cycle 52.
Same run, stage 1 (D=8): r=0 -> ODD 0, r=1 -> ODD 7, r=3 -> ODD 5, COEF=3; stage 2 (D=4): r=5 -> ODD 7, COEF 2, oSECTOR 1.
iLOG_LEN=15 with A_BIT=4 -> clamped L=4, 6 stages of 18 ticks; iLOG_LEN=1 -> L=2, 4 stages of 6 ticks.
iHOLD high 7 cycles in mid stage 2 -> no WE, addresses frozen, oDONE delayed exactly 7 cycles.
iRESET pulse at cycle 20 -> next cycle all outputs 0, oRDY=1, no oDONE; iSTART during RUN ignored.
FHT_CTRL_HALF_RATE_EN defined, first run repeated -> oDONE at cycle 101, WE high on alternate cycles only.
